// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 inverse cipher: one round per clock on a shared datapath, with round keys
// produced on the fly (forward expansion to rk10, then the inverse schedule back to rk0).

package aes_dec_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Undoes xtime: walks the Rcon sequence backwards (0x36 -> 0x1b -> 0x80 ... -> 0x01).
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

endpackage

// Forward S-box: GF(2^8) inverse followed by the affine map.
module aes_sbox
  import aes_dec_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  logic [7:0] inv;

  // Affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
  always_comb begin
    inv   = gf_inv(in_i);
    out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
            {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// Inverse S-box: inverse affine map followed by the GF(2^8) inverse.
module aes_inv_sbox
  import aes_dec_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  logic [7:0] pre;

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
  always_comb begin
    pre   = {in_i[6:0], in_i[7]} ^ {in_i[4:0], in_i[7:5]} ^ {in_i[1:0], in_i[7:2]} ^ 8'h05;
    out_o = gf_inv(pre);
  end
endmodule

module aes_decrypt_iterative
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] IN_DATA,
  input  logic [127:0] IN_KEY,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] OUT_DATA,
  output logic         BUSY
);

  typedef enum logic [2:0] {StIdle, StKexp, StArk0, StRound, StFinal, StDone} st_e;

  st_e          fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  // State path
  logic [7:0]   shifted [16];
  logic [7:0]   inv_sub [16];
  logic [127:0] sub_pk;

  // Key path
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_in, rot_in, sub_word;
  logic [7:0]   next_rcon;
  logic [127:0] fwd_key, inv_key;

  // InvShiftRows (row r rotates right by r) and packing of the InvSubBytes result
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        shifted[r + 4 * c] = state_q[127 - 8 * (r + 4 * ((c - r) & 3)) -: 8];
      end
    end
    sub_pk = '0;
    for (int i = 0; i < 16; i++) begin
      sub_pk[127 - 8 * i -: 8] = inv_sub[i];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (
      .in_i  (shifted[i]),
      .out_o (inv_sub[i])
    );
  end

  // One SubWord(RotWord()) serves both directions: forward uses w3, inverse uses the
  // recovered previous w3, which is w3 ^ w2.
  always_comb begin
    w0        = key_q[127:96];
    w1        = key_q[95:64];
    w2        = key_q[63:32];
    w3        = key_q[31:0];
    sub_in    = (fsm_q == StKexp) ? w3 : (w3 ^ w2);
    rot_in    = {sub_in[23:0], sub_in[31:24]};
    next_rcon = (rcon_q == 8'h00) ? 8'h01 : xtime(rcon_q);
  end

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (
      .in_i  (rot_in[31 - 8 * i -: 8]),
      .out_o (sub_word[31 - 8 * i -: 8])
    );
  end

  // Forward and inverse key-schedule steps
  always_comb begin
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] p0, p1, p2, p3;
    f0      = w0 ^ sub_word ^ {next_rcon, 24'h000000};
    f1      = w1 ^ f0;
    f2      = w2 ^ f1;
    f3      = w3 ^ f2;
    fwd_key = {f0, f1, f2, f3};
    p3      = w3 ^ w2;
    p2      = w2 ^ w1;
    p1      = w1 ^ w0;
    p0      = w0 ^ sub_word ^ {rcon_q, 24'h000000};
    inv_key = {p0, p1, p2, p3};
  end

  // Next-state logic for the control FSM and datapath registers
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    rcon_d      = rcon_q;
    rnd_d       = rnd_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (fsm_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (IN_VALID && in_ready_q) begin
          state_d    = IN_DATA;
          key_d      = IN_KEY;
          rnd_d      = 4'd0;
          rcon_d     = 8'h00;
          in_ready_d = 1'b0;
          fsm_d      = StKexp;
        end
      end
      StKexp: begin
        key_d  = fwd_key;
        rcon_d = next_rcon;
        rnd_d  = rnd_q + 4'd1;
        if (rnd_q == 4'd9) fsm_d = StArk0;
      end
      StArk0: begin
        state_d = state_q ^ key_q;
        key_d   = inv_key;
        rcon_d  = inv_xtime(rcon_q);
        rnd_d   = 4'd9;
        fsm_d   = StRound;
      end
      StRound: begin
        state_d = inv_mix_columns(sub_pk ^ key_q);
        key_d   = inv_key;
        rcon_d  = inv_xtime(rcon_q);
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = StFinal;
      end
      StFinal: begin
        state_d     = sub_pk ^ key_q;
        out_valid_d = 1'b1;
        fsm_d       = StDone;
      end
      StDone: begin
        if (out_valid_q && OUT_READY) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          fsm_d       = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      key_q       <= '0;
      rcon_q      <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      rcon_q      <= rcon_d;
      rnd_q       <= rnd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = state_q;
  assign BUSY      = (fsm_q != StIdle);

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Bench for aes_decrypt_iterative: FIPS-197 vectors, random blocks checked against a
// table-driven AES-128 encryption model, backpressure, busy-input, reset and back-to-back cases.

module tb_aes_decrypt_iterative;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         IN_VALID;
  logic         IN_READY;
  logic [127:0] IN_DATA;
  logic [127:0] IN_KEY;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [127:0] OUT_DATA;
  logic         BUSY;

  int vectors = 0;
  int miscompares = 0;

  aes_decrypt_iterative dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_KEY    (IN_KEY),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .BUSY      (BUSY)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0]  sb [256];
  logic [31:0] kw [44];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box from its definition: brute-force inverse, then the bitwise affine formula.
  function void build_sbox();
    logic [7:0] y, c, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      for (int k = 1; k < 256; k++) if (gm(8'(x), 8'(k)) == 8'h01) y = 8'(k);
      for (int i = 0; i < 8; i++)
        s[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8] ^ y[(i + 6) % 8] ^ y[(i + 7) % 8] ^ c[i];
      sb[x] = s;
    end
  endfunction

  function void expand(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) kw[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = kw[i - 1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'd0};
        rc = xt(rc);
      end
      kw[i] = kw[i - 4] ^ t;
    end
  endfunction

  function automatic logic [127:0] rk10_of(input logic [127:0] key);
    expand(key);
    return {kw[40], kw[41], kw[42], kw[43]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    expand(key);
    for (int b = 0; b < 16; b++) s[b] = pt[127 - 8 * b -: 8] ^ kw[b / 4][31 - 8 * (b % 4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) s[row + 4 * c] = t[row + 4 * ((c + row) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
          s[4 * c]     = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
          s[4 * c + 3] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ kw[4 * r + b / 4][31 - 8 * (b % 4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127 - 8 * b -: 8] = s[b];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One job: hold = cycles OUT_READY stays low after OUT_VALID; disturb = poke inputs mid-run;
  // chk_rk = compare the internal key against rk10 at ARK0 entry.
  task automatic do_job(input string tag, input logic [127:0] ct, input logic [127:0] key,
                        input logic [127:0] exp, input int hold, input bit disturb,
                        input bit chk_rk);
    int n;
    n = 0;
    while (!IN_READY && n < 50) begin step(); n++; end
    chk({tag, " ready"}, {127'd0, IN_READY}, 128'd1);
    OUT_READY = (hold == 0);
    IN_VALID  = 1'b1;
    IN_DATA   = ct;
    IN_KEY    = key;
    step();
    IN_VALID = 1'b0;
    n = 0;
    while (!OUT_VALID && n < 40) begin
      step();
      n++;
      if (chk_rk && n == 10) chk({tag, " rk10"}, dut.key_q, rk10_of(key));
      if (disturb && n == 14) begin
        IN_VALID = 1'b1; IN_DATA = rnd128(); IN_KEY = rnd128(); OUT_READY = 1'b0;
      end
      if (disturb && n == 15) begin IN_VALID = 1'b0; OUT_READY = 1'b1; end
    end
    chk({tag, " latency"}, 128'(n), 128'd21);
    chk({tag, " data"}, OUT_DATA, exp);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, " stall flags"}, {126'd0, OUT_VALID, IN_READY}, 128'd2);
      chk({tag, " stall data"}, OUT_DATA, exp);
    end
    OUT_READY = 1'b1;
    step();
    chk({tag, " handshake"}, {126'd0, OUT_VALID, IN_READY}, 128'd1);
  endtask

  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    logic [127:0] pt, key;
    int n, d;
    build_sbox();
    rst_n     = 1'b0;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    IN_KEY    = '0;
    OUT_READY = 1'b1;

    // Reset values
    #12;
    chk("reset flags", {125'd0, IN_READY, OUT_VALID, BUSY}, 128'd0);
    chk("reset data", OUT_DATA, 128'd0);
    rst_n = 1'b1;
    step();
    chk("ready after reset", {127'd0, IN_READY}, 128'd1);

    // FIPS-197 vectors, with a direct rk10 check on App. B
    do_job("c1", C1Ct, C1Key, C1Pt, 0, 1'b0, 1'b0);
    do_job("appb", BCt, BKey, BPt, 0, 1'b0, 1'b1);
    chk("appb rk10 const", rk10_of(BKey) ^ BRk10, 128'd0);

    // Backpressure and ignored inputs while busy
    do_job("c1 stall", C1Ct, C1Key, C1Pt, 50, 1'b0, 1'b0);
    do_job("c1 busy-in", C1Ct, C1Key, C1Pt, 0, 1'b1, 1'b0);

    // Random blocks: ciphertext from the encryption model, plaintext must come back
    for (int i = 0; i < 4; i++) begin
      pt  = rnd128();
      key = rnd128();
      do_job("random", aes_enc(pt, key), key, pt, 0, 1'b0, 1'b0);
    end

    // Reset mid-job, 12 edges after acceptance
    IN_VALID = 1'b1; IN_DATA = C1Ct; IN_KEY = C1Key;
    step();
    IN_VALID = 1'b0;
    for (int i = 0; i < 11; i++) step();
    chk("busy before reset", {127'd0, BUSY}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset flags", {125'd0, IN_READY, OUT_VALID, BUSY}, 128'd0);
    chk("midreset data", OUT_DATA, 128'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("midreset no output", {126'd0, OUT_VALID, IN_READY}, 128'd1);
    do_job("appb after reset", BCt, BKey, BPt, 0, 1'b0, 1'b0);

    // Back-to-back with IN_VALID held high
    OUT_READY = 1'b1;
    IN_VALID = 1'b1; IN_DATA = C1Ct; IN_KEY = C1Key;
    step();
    IN_DATA = BCt; IN_KEY = BKey;
    n = 0;
    while (!OUT_VALID && n < 40) begin step(); n++; end
    chk("b2b first data", OUT_DATA, C1Pt);
    d = 0;
    step(); d++;
    while (!OUT_VALID && d < 60) begin step(); d++; end
    IN_VALID = 1'b0;
    chk("b2b second data", OUT_DATA, BPt);
    chk("b2b spacing", 128'(d), 128'd23);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
